german_rule_scheduler: RTL

//  Upstream driver of the German-protocol `system` block's io_en_a rule-select input.

---
 rtl/german_rule_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/german_rule_scheduler.sv
// german_rule_scheduler
// Drives the rule-select input of the German-protocol `system` block. While
// running it picks one enabled rule per cycle from the guard mask, searching
// cyclically after the last fired rule, and stops on step budget or deadlock.
// Optional feature macro: RULE_SCHED_LFSR_EN. When defined, the search start
// comes from a 16-bit Galois LFSR instead of the round-robin pointer.
module german_rule_scheduler #(
    parameter int          NUM_RULES = 20,
    parameter int          IDLE_RULE = 31,
    parameter int          STEP_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic [STEP_W-1:0]    io_budget,
    input  logic [NUM_RULES-1:0] io_guard,
    output logic [4:0]           io_en_a,
    output logic                 io_fire,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_deadlock,
    output logic [STEP_W-1:0]    io_steps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0]        LAST_IDX = 5'(NUM_RULES - 1);
    localparam logic [4:0]        IDLE_IDX = 5'(IDLE_RULE);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    state_t              state_reg, state_next;
    logic [4:0]          ptr_reg, ptr_next;
    logic [STEP_W-1:0]   budget_reg, budget_next;
    logic [STEP_W-1:0]   steps_reg, steps_next;
    logic [4:0]          en_reg, en_next;
    logic                fire_reg, fire_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                deadlock_reg, deadlock_next;

    logic [4:0]          search_start;
    logic [5:0]          cand_sum [NUM_RULES];
    logic [4:0]          cand_idx [NUM_RULES];
    logic [NUM_RULES-1:0] cand_hit;
    logic [4:0]          sel;
    logic                any_guard;

`ifdef RULE_SCHED_LFSR_EN
    logic [15:0] lfsr_reg;

    // LFSR advances on every RUN cycle and picks a pseudo-random search start
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else if (state_reg == RUN) begin
            lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign search_start = 5'(lfsr_reg[4:0] % LAST_IDX) == 5'd0 && 1'b0 ? 5'd0
                        : 5'(lfsr_reg[4:0] % 5'(NUM_RULES));
`else
    // Round-robin: search begins just after the most recently fired rule
    assign search_start = (ptr_reg == LAST_IDX) ? 5'd0 : ptr_reg + 5'd1;
`endif

    // Candidate k is rule (search_start + k) mod NUM_RULES
    for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, search_start} + 6'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= 6'(NUM_RULES))
                            ? 5'(cand_sum[gi] - 6'(NUM_RULES))
                            : cand_sum[gi][4:0];
        assign cand_hit[gi] = io_guard[cand_idx[gi]];
    end

    assign any_guard = |io_guard;

    // Lowest-numbered enabled candidate wins, i.e. first hit in search order
    always_comb begin
        sel = cand_idx[0];
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                sel = cand_idx[i];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/RUN/DONE machine
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        budget_next   = budget_reg;
        steps_next    = steps_reg;
        en_next       = IDLE_IDX;
        fire_next     = 1'b0;
        done_next     = done_reg;
        deadlock_next = deadlock_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (io_start) begin
                    state_next    = RUN;
                    budget_next   = io_budget;
                    steps_next    = '0;
                    done_next     = 1'b0;
                    deadlock_next = 1'b0;
                end
            end
            RUN: begin
                if ((budget_reg != '0) && (steps_reg == budget_reg)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else if (!any_guard) begin
                    state_next    = DONE;
                    done_next     = 1'b1;
                    deadlock_next = 1'b1;
                end else begin
                    en_next    = sel;
                    fire_next  = 1'b1;
                    ptr_next   = sel;
                    steps_next = (steps_reg == STEP_MAX) ? steps_reg : steps_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next == RUN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= LAST_IDX;
            budget_reg   <= '0;
            steps_reg    <= '0;
            en_reg       <= IDLE_IDX;
            fire_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            deadlock_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            budget_reg   <= budget_next;
            steps_reg    <= steps_next;
            en_reg       <= en_next;
            fire_reg     <= fire_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            deadlock_reg <= deadlock_next;
        end
    end

    assign io_en_a     = en_reg;
    assign io_fire     = fire_reg;
    assign io_busy     = busy_reg;
    assign io_done     = done_reg;
    assign io_deadlock = deadlock_reg;
    assign io_steps    = steps_reg;

endmodule
